// File: rtl/conv_pkg.sv
// Shared bfloat16 helpers for the post-processing stages behind the
// convolution-layer calculator.
//   bf16_t          : raw bfloat16 bit pattern (1 sign, 8 exponent, 7 mantissa)
//   bf16_relu       : clamps anything with the sign bit set (incl. -0, -NaN) to +0
//   bf16_max_nonneg : max of two non-negative values via unsigned compare
package conv_pkg;

  typedef logic [15:0] bf16_t;

  localparam int BF16_W = 16;

  function automatic bf16_t bf16_relu(input bf16_t x);
    return x[15] ? 16'h0000 : x;
  endfunction

  // For sign=0 patterns the IEEE ordering matches the unsigned ordering of the
  // raw bits, with +Inf and +NaN landing on top.
  function automatic bf16_t bf16_max_nonneg(input bf16_t a, input bf16_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_counter.sv
// Raster position counter for a K x OH x OH stream (filter-major, row-major).
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous return to (chan 0, row 0, col 0)
//   advance     : step one element
//   col/row/chan: current position of the element being presented
//   col_wrap    : current element is the last of its row
//   row_wrap    : current element is the last of its filter plane
//   frame_wrap  : current element is the last of the whole frame
module pool_counter #(
  parameter  int OH  = 8,
  parameter  int K   = 4,
  localparam int CW  = (OH > 1) ? $clog2(OH) : 1,
  localparam int CHW = (K > 1) ? $clog2(K) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           advance,
  output logic [CW-1:0]  col,
  output logic [CW-1:0]  row,
  output logic [CHW-1:0] chan,
  output logic           col_wrap,
  output logic           row_wrap,
  output logic           frame_wrap
);

  assign col_wrap   = (col == CW'(OH - 1));
  assign row_wrap   = col_wrap && (row == CW'(OH - 1));
  assign frame_wrap = row_wrap && (chan == CHW'(K - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (advance) begin
      col <= col_wrap ? '0 : col + CW'(1);
      if (col_wrap) row <= row_wrap ? '0 : row + CW'(1);
      if (row_wrap) chan <= frame_wrap ? '0 : chan + CHW'(1);
    end
  end

endmodule

// File: rtl/ofmap_relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling on a streamed bfloat16 ofmap.
//   clk, rst_n     : clock, async active-low reset
//   iClear         : synchronous flush of counters, pair register and oValid
//   iData, iValid  : input element and its valid; accepted when iValid && oReady
//   oReady         : stage can take iData this cycle
//   oData, oValid  : pooled element and its valid; handed off when oValid && iReady
//   iReady         : downstream accepts oData
//   oChan          : filter index of oData
//   oLast          : oData is the final pooled element of its filter
//   oDone          : one-cycle pulse after the final element of filter K-1 leaves
module ofmap_relu_maxpool
  import conv_pkg::*;
#(
  parameter  int BW  = 16,
  parameter  int K   = 4,
  parameter  int OH  = 8,
  localparam int CHW = (K > 1) ? $clog2(K) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           iClear,
  input  logic [BW-1:0]  iData,
  input  logic           iValid,
  output logic           oReady,
  output logic [BW-1:0]  oData,
  output logic           oValid,
  input  logic           iReady,
  output logic [CHW-1:0] oChan,
  output logic           oLast,
  output logic           oDone
);

  localparam int PH  = OH / 2;
  localparam int P2  = 2 * PH;
  localparam int CW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int LBW = (PH > 1) ? $clog2(PH) : 1;

  logic [CW-1:0]  col, row;
  logic [CHW-1:0] chan;
  logic           col_wrap, row_wrap, frame_wrap;

  logic           accept, in_grid, pair_we, lb_we, produce, is_last;
  logic [LBW-1:0] lb_idx;
  bf16_t          relu_val, pair_q, pair_max, pool_max;
  bf16_t          line_buf [PH];

  assign oReady = (!oValid || iReady) && !iClear;
  assign accept = iValid && oReady;

  pool_counter #(.OH(OH), .K(K)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (iClear),
    .advance    (accept),
    .col        (col),
    .row        (row),
    .chan       (chan),
    .col_wrap   (col_wrap),
    .row_wrap   (row_wrap),
    .frame_wrap (frame_wrap)
  );

  // With odd OH the trailing row and column fall outside every 2x2 window.
  // The extra bit keeps P2 == 2^CW representable.
  assign in_grid = ({1'b0, col} < (CW + 1)'(P2)) && ({1'b0, row} < (CW + 1)'(P2));
  assign pair_we = accept && in_grid && !col[0];
  assign lb_we   = accept && in_grid && col[0] && !row[0];
  assign produce = accept && in_grid && col[0] && row[0];
  assign is_last = (row == CW'(P2 - 1)) && (col == CW'(P2 - 1));
  assign lb_idx  = LBW'(col >> 1);

  assign relu_val = bf16_relu(bf16_t'(iData));
  assign pair_max = bf16_max_nonneg(pair_q, relu_val);
  assign pool_max = bf16_max_nonneg(line_buf[lb_idx], pair_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
    end else if (iClear) begin
      pair_q <= '0;
    end else if (pair_we) begin
      pair_q <= relu_val;
    end
  end

  // Every slot is rewritten on the even row before the odd row reads it, so
  // the buffer needs neither reset nor flush.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf[lb_idx] <= pair_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid <= 1'b0;
      oData  <= '0;
      oChan  <= '0;
      oLast  <= 1'b0;
      oDone  <= 1'b0;
    end else if (iClear) begin
      oValid <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      oDone <= oValid && iReady && oLast && (oChan == CHW'(K - 1));
      if (produce) begin
        oValid <= 1'b1;
        oData  <= BW'(pool_max);
        oChan  <= chan;
        oLast  <= is_last;
      end else if (iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofmap_relu_maxpool.sv
module tb_ofmap_relu_maxpool;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  chan;
    logic        last;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Three instances: 0 -> OH=4,K=2 ; 1 -> OH=5,K=1 ; 2 -> OH=8,K=4
  logic [15:0] in_data  [3];
  logic        in_valid [3];
  logic        in_clear [3];
  logic        dn_ready [3];
  logic [15:0] out_data [3];
  logic        out_valid[3];
  logic        out_last [3];
  logic        out_done [3];
  logic        out_rdy  [3];
  logic [1:0]  out_chan [3];
  logic [0:0]  chan_a, chan_b;
  logic [1:0]  chan_c;

  assign out_chan[0] = {1'b0, chan_a};
  assign out_chan[1] = {1'b0, chan_b};
  assign out_chan[2] = chan_c;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   out_cnt [3];
  int   last_cnt[3];
  int   done_cnt[3];
  pkt_t sb_q [3][$];
  logic [15:0] frm [4][8][8];

  ofmap_relu_maxpool #(.BW(16), .K(2), .OH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .iClear(in_clear[0]), .iData(in_data[0]), .iValid(in_valid[0]),
    .oReady(out_rdy[0]), .oData(out_data[0]), .oValid(out_valid[0]), .iReady(dn_ready[0]),
    .oChan(chan_a), .oLast(out_last[0]), .oDone(out_done[0]));

  ofmap_relu_maxpool #(.BW(16), .K(1), .OH(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .iClear(in_clear[1]), .iData(in_data[1]), .iValid(in_valid[1]),
    .oReady(out_rdy[1]), .oData(out_data[1]), .oValid(out_valid[1]), .iReady(dn_ready[1]),
    .oChan(chan_b), .oLast(out_last[1]), .oDone(out_done[1]));

  ofmap_relu_maxpool #(.BW(16), .K(4), .OH(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .iClear(in_clear[2]), .iData(in_data[2]), .iValid(in_valid[2]),
    .oReady(out_rdy[2]), .oData(out_data[2]), .oValid(out_valid[2]), .iReady(dn_ready[2]),
    .oChan(chan_c), .oLast(out_last[2]), .oDone(out_done[2]));

  function automatic int oh_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 5 : 8;
  endfunction

  function automatic int k_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 4;
  endfunction

  function automatic logic [15:0] ref_relu(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  // Scoreboard: each handoff pops the oldest expectation; oDone is checked
  // on the cycle that follows every handoff.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int KG = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic chk_done;
    logic exp_done;
    pkt_t p;
    initial begin
      chk_done = 1'b0;
      exp_done = 1'b0;
    end
    always @(negedge clk) begin
      if (!rst_n) begin
        chk_done = 1'b0;
      end else begin
        if (chk_done) begin
          total_cnt++;
          if (out_done[g] !== exp_done)
            $display("FAIL odone_%0d: got %0b expected %0b", g, out_done[g], exp_done);
          else
            pass_cnt++;
        end
        chk_done = 1'b0;
        if (out_done[g] === 1'b1) done_cnt[g]++;
        if (out_valid[g] && dn_ready[g] && !in_clear[g]) begin
          out_cnt[g]++;
          if (out_last[g]) last_cnt[g]++;
          total_cnt++;
          if (sb_q[g].size() == 0) begin
            $display("FAIL unexpected_out_%0d: got data %h with nothing expected", g, out_data[g]);
          end else begin
            p = sb_q[g].pop_front();
            if (out_data[g] !== p.data || out_chan[g] !== p.chan || out_last[g] !== p.last)
              $display("FAIL out_%0d: got data %h chan %0d last %0b expected data %h chan %0d last %0b",
                       g, out_data[g], out_chan[g], out_last[g], p.data, p.chan, p.last);
            else
              pass_cnt++;
            exp_done = p.last && (int'(p.chan) == KG - 1);
            chk_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [15:0] d);
    int n = 0;
    in_data[g]  = d;
    in_valid[g] = 1'b1;
    @(negedge clk);
    while (!out_rdy[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total_cnt++;
      $display("FAIL push_timeout_%0d: oReady stayed 0 expected 1 within 400 cycles", g);
    end
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic build_expected(input int g);
    int oh = oh_of(g);
    int ph = oh / 2;
    for (int c = 0; c < k_of(g); c++)
      for (int pr = 0; pr < ph; pr++)
        for (int pc = 0; pc < ph; pc++) begin
          pkt_t e;
          logic [15:0] m = 16'h0000;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (ref_relu(frm[c][2*pr+dr][2*pc+dc]) > m) m = ref_relu(frm[c][2*pr+dr][2*pc+dc]);
          e.data = m;
          e.chan = 2'(c);
          e.last = (pr == ph - 1) && (pc == ph - 1);
          sb_q[g].push_back(e);
        end
  endtask

  task automatic stream_frame(input int g, input bit gaps);
    for (int c = 0; c < k_of(g); c++)
      for (int r = 0; r < oh_of(g); r++)
        for (int cl = 0; cl < oh_of(g); cl++) begin
          if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) cycle();
          push(g, frm[c][r][cl]);
        end
  endtask

  task automatic fill_frame(input logic [15:0] v);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++)
        for (int cl = 0; cl < 8; cl++)
          frm[c][r][cl] = v;
  endtask

  task automatic drain(input int g, output bit ok);
    int n = 0;
    while (sb_q[g].size() != 0 && n < 2000) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    ok = (sb_q[g].size() == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      in_clear[g] = 1'b0;
      dn_ready[g] = 1'b1;
      in_data[g]  = 16'h0000;
      out_cnt[g]  = 0;
      last_cnt[g] = 0;
      done_cnt[g] = 0;
    end
    repeat (3) cycle();
    for (int g = 0; g < 3; g++) begin
      total_cnt++;
      if ({out_valid[g], out_data[g], out_chan[g], out_last[g], out_done[g]} !== 21'd0)
        $display("FAIL reset_outs_%0d: got valid %0b data %h chan %0d last %0b done %0b expected all 0",
                 g, out_valid[g], out_data[g], out_chan[g], out_last[g], out_done[g]);
      else
        pass_cnt++;
      total_cnt++;
      if (out_rdy[g] !== 1'b1)
        $display("FAIL reset_ready_%0d: got %0b expected 1", g, out_rdy[g]);
      else
        pass_cnt++;
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    logic [15:0] rows [4][4];
    bit ok;
    int oc0 = out_cnt[0];
    int dc0 = done_cnt[0];
    rows = '{'{16'h3F80, 16'h4000, 16'h3F00, 16'h3F00},
             '{16'hBF80, 16'h4040, 16'h3F00, 16'h4000},
             '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
             '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    fill_frame(16'h0000);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        frm[0][r][c] = rows[r][c];
    build_expected(0);
    total_cnt++;
    if (sb_q[0][0].data !== 16'h4040 || sb_q[0][1].data !== 16'h4000)
      $display("FAIL basic_model: got %h %h expected 4040 4000", sb_q[0][0].data, sb_q[0][1].data);
    else
      pass_cnt++;
    stream_frame(0, 1'b0);
    drain(0, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_drain: got %0d pending expected 0", sb_q[0].size());
    else pass_cnt++;
    total_cnt++;
    if (out_cnt[0] - oc0 != 8) $display("FAIL basic_count: got %0d expected 8", out_cnt[0] - oc0);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt[0] - dc0 != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt[0] - dc0);
    else pass_cnt++;
  endtask

  task automatic test_negative();
    bit ok;
    int oc0 = out_cnt[0];
    int lc0 = last_cnt[0];
    fill_frame(16'hBF80);
    frm[1][1][1] = 16'hFFC1;
    frm[1][2][3] = 16'h8000;
    build_expected(0);
    stream_frame(0, 1'b0);
    drain(0, ok);
    total_cnt++;
    if (!ok) $display("FAIL neg_drain: got %0d pending expected 0", sb_q[0].size());
    else pass_cnt++;
    total_cnt++;
    if (out_cnt[0] - oc0 != 8 || last_cnt[0] - lc0 != 2)
      $display("FAIL neg_count: got %0d outs %0d lasts expected 8 outs 2 lasts", out_cnt[0] - oc0, last_cnt[0] - lc0);
    else
      pass_cnt++;
  endtask

  task automatic test_odd_size();
    bit ok;
    int oc1 = out_cnt[1];
    fill_frame(16'h3F80);
    frm[0][4][4] = 16'h4F00;
    frm[0][0][4] = 16'h4F00;
    build_expected(1);
    stream_frame(1, 1'b0);
    drain(1, ok);
    total_cnt++;
    if (out_cnt[1] - oc1 != 4) $display("FAIL odd_count: got %0d expected 4", out_cnt[1] - oc1);
    else pass_cnt++;
    total_cnt++;
    if (out_valid[1] !== 1'b0) $display("FAIL odd_tail_valid: got %0b expected 0", out_valid[1]);
    else pass_cnt++;
    // A second frame shows the counters wrapped cleanly after the 25th input.
    fill_frame(16'h4000);
    frm[0][1][1] = 16'h4100;
    build_expected(1);
    stream_frame(1, 1'b0);
    drain(1, ok);
    total_cnt++;
    if (!ok || out_cnt[1] - oc1 != 8)
      $display("FAIL odd_second_frame: got %0d outs %0d pending expected 8 outs 0 pending",
               out_cnt[1] - oc1, sb_q[1].size());
    else
      pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen = 1'b0;
    int oc0 = out_cnt[0];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++)
        for (int cl = 0; cl < 8; cl++)
          frm[c][r][cl] = 16'h3C00 + 16'($urandom_range(0, 1023));
    build_expected(0);
    fork
      stream_frame(0, 1'b0);
      begin
        pkt_t first;
        first = sb_q[0][0];
        for (int n = 0; n < 200 && !seen; n++) begin
          @(posedge clk);
          #1;
          if (out_valid[0]) begin
            seen = 1'b1;
            dn_ready[0] = 1'b0;
          end
        end
        total_cnt++;
        if (!seen) $display("FAIL bp_first_valid: got none expected an output within 200 cycles");
        else pass_cnt++;
        if (seen) begin
          for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== first.data || out_chan[0] !== first.chan || out_rdy[0] !== 1'b0)
              $display("FAIL bp_hold: got valid %0b data %h chan %0d ready %0b expected 1 %h %0d 0",
                       out_valid[0], out_data[0], out_chan[0], out_rdy[0], first.data, first.chan);
            else
              pass_cnt++;
          end
          @(posedge clk);
          #1;
          dn_ready[0] = 1'b1;
        end
      end
    join
    drain(0, ok);
    total_cnt++;
    if (!ok || out_cnt[0] - oc0 != 8)
      $display("FAIL bp_count: got %0d outs %0d pending expected 8 outs 0 pending", out_cnt[0] - oc0, sb_q[0].size());
    else
      pass_cnt++;
  endtask

  task automatic test_random();
    bit ok;
    bit rnd_done = 1'b0;
    int oc2 = out_cnt[2];
    int lc2 = last_cnt[2];
    int dc2 = done_cnt[2];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++)
        for (int cl = 0; cl < 8; cl++) begin
          logic [15:0] v = 16'($urandom());
          if (v[14:7] == 8'hFF) v[14] = 1'b0;
          frm[c][r][cl] = v;
        end
    build_expected(2);
    fork
      begin
        stream_frame(2, 1'b1);
        drain(2, ok);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          dn_ready[2] = ($urandom_range(0, 2) != 0);
        end
        dn_ready[2] = 1'b1;
      end
    join
    repeat (3) cycle();
    total_cnt++;
    if (!ok || out_cnt[2] - oc2 != 64)
      $display("FAIL rand_count: got %0d outs %0d pending expected 64 outs 0 pending", out_cnt[2] - oc2, sb_q[2].size());
    else
      pass_cnt++;
    total_cnt++;
    if (last_cnt[2] - lc2 != 4 || done_cnt[2] - dc2 != 1)
      $display("FAIL rand_last_done: got %0d lasts %0d dones expected 4 lasts 1 done", last_cnt[2] - lc2, done_cnt[2] - dc2);
    else
      pass_cnt++;
  endtask

  // Leaves an output pending on instance 0 with a 0x4F00 line buffer behind it.
  task automatic load_stale();
    dn_ready[0] = 1'b0;
    for (int n = 0; n < 6; n++) push(0, 16'h4F00);
  endtask

  task automatic clean_frame_check(input string tag);
    bit ok;
    int oc0 = out_cnt[0];
    fill_frame(16'h3F80);
    build_expected(0);
    stream_frame(0, 1'b0);
    drain(0, ok);
    total_cnt++;
    if (!ok || out_cnt[0] - oc0 != 8)
      $display("FAIL %s_fresh_frame: got %0d outs %0d pending expected 8 outs 0 pending", tag, out_cnt[0] - oc0, sb_q[0].size());
    else
      pass_cnt++;
  endtask

  task automatic test_mid_reset();
    load_stale();
    total_cnt++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h4F00)
      $display("FAIL rst_pending: got valid %0b data %h expected 1 4f00", out_valid[0], out_data[0]);
    else
      pass_cnt++;
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 16'h0000)
      $display("FAIL rst_mid: got valid %0b data %h expected 0 0000", out_valid[0], out_data[0]);
    else
      pass_cnt++;
    dn_ready[0] = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    clean_frame_check("rst");
  endtask

  task automatic test_clear();
    load_stale();
    in_clear[0] = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (out_rdy[0] !== 1'b0) $display("FAIL clr_ready: got %0b expected 0", out_rdy[0]);
    else pass_cnt++;
    @(posedge clk);
    #1;
    in_clear[0] = 1'b0;
    total_cnt++;
    if (out_valid[0] !== 1'b0) $display("FAIL clr_valid: got %0b expected 0", out_valid[0]);
    else pass_cnt++;
    dn_ready[0] = 1'b1;
    cycle();
    clean_frame_check("clr");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_odd_size();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_clear();
    repeat (5) cycle();
    for (int g = 0; g < 3; g++) begin
      total_cnt++;
      if (sb_q[g].size() != 0) $display("FAIL final_pending_%0d: got %0d expected 0", g, sb_q[g].size());
      else pass_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
